// File: rtl/btn_color_sel.sv
// btn_color_sel: push-button front end for the RGB LED bank.
// Each raw button goes through a 2-flop synchroniser, a counter debouncer
// and a rising-edge detector. The resulting presses update a registered
// one-hot colour select. When several buttons press in the same cycle, the
// highest index wins.
//
// Ports:
//   clock      system clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   i_btn_raw  raw button levels, active-high, asynchronous
//   o_sel      registered one-hot colour select (bit COLOR-1 = red, 0 = blue)
//   o_sel_upd  one-cycle pulse in the cycle o_sel takes a new value
//   o_btn_db   debounced button levels

// Per-button lane: synchroniser, debouncer and press detector.
//   clock, i_reset_n  as top
//   raw               raw button level
//   sync_vld          high once the synchroniser holds post-reset samples
//   db                debounced level
//   press             one-cycle rising-edge pulse of db, suppressed until armed
module btn_color_sel_lane #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clock,
    input  logic i_reset_n,
    input  logic raw,
    input  logic sync_vld,
    output logic db,
    output logic press
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] LIM = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_ff;
    logic          sync;
    logic [CW-1:0] cnt;
    logic          db_q;
    logic          armed;

    assign sync = sync_ff[1];

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_ff <= '0;
            cnt     <= '0;
            db      <= 1'b0;
            db_q    <= 1'b0;
            armed   <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[0], raw};
            db_q    <= db;
            // Any return to the current debounced level restarts the count.
            if (sync == db) begin
                cnt <= '0;
            end else if (cnt == LIM) begin
                db  <= sync;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            // The lane must see the button genuinely released before it
            // reports presses. This keeps a button held through reset from
            // producing a spurious press when it debounces high.
            if (sync_vld && !sync && !db)
                armed <= 1'b1;
        end
    end

    assign press = db & ~db_q & armed;
endmodule

module btn_color_sel #(
    parameter int              COLOR      = 3,
    parameter int              DEB_CYCLES = 1000000,
    parameter logic [COLOR-1:0] RST_SEL   = COLOR'(3'b100)
) (
    input  logic             clock,
    input  logic             i_reset_n,
    input  logic [COLOR-1:0] i_btn_raw,
    output logic [COLOR-1:0] o_sel,
    output logic             o_sel_upd,
    output logic [COLOR-1:0] o_btn_db
);
    logic [COLOR-1:0] press;
    logic [COLOR-1:0] nxt_sel;
    // Synchroniser contents are only meaningful two cycles after reset.
    logic [1:0]       vld_pipe;

    for (genvar k = 0; k < COLOR; k++) begin : g_lane
        btn_color_sel_lane #(.DEB_CYCLES(DEB_CYCLES)) u_lane (
            .clock    (clock),
            .i_reset_n(i_reset_n),
            .raw      (i_btn_raw[k]),
            .sync_vld (vld_pipe[1]),
            .db       (o_btn_db[k]),
            .press    (press[k])
        );
    end

    // The loop visits indices in ascending order, so the highest pressed
    // index is the one that sticks.
    always_comb begin
        nxt_sel = '0;
        for (int k = 0; k < COLOR; k++) begin
            if (press[k]) begin
                nxt_sel    = '0;
                nxt_sel[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vld_pipe  <= '0;
            o_sel     <= RST_SEL;
            o_sel_upd <= 1'b0;
        end else begin
            vld_pipe  <= {vld_pipe[0], 1'b1};
            o_sel_upd <= 1'b0;
            if (|press && nxt_sel != o_sel) begin
                o_sel     <= nxt_sel;
                o_sel_upd <= 1'b1;
            end
        end
    end
endmodule

// File: doc/btn_color_sel.md
Name: btn_color_sel

Overview:
- Input-side front end for the RGB LED bank: turns raw board push-buttons into the one-hot colour-select bus that the LED colour router consumes.
- Per button: synchronises, debounces and rising-edge detects the raw input.
- Holds a registered one-hot colour selection; each new press changes it.
- Sits between the board button pins and the LED block's colour-select input.

Parameters:
- COLOR, 3, number of colour buttons/select lines. Bit COLOR-1 = red, bit 1 = green, bit 0 = blue.
- DEB_CYCLES, 1000000, consecutive stable cycles required before a debounced level changes (10 ms at 100 MHz).
- RST_SEL, 3'b100, one-hot selection loaded on reset. Must be one-hot or zero, width COLOR.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_btn_raw  in  COLOR  raw asynchronous button levels, active-high.
- o_sel  out  COLOR  registered one-hot colour select, driven to the LED block's colour-select input.
- o_sel_upd  out  1  single-cycle pulse when o_sel changes value.
- o_btn_db  out  COLOR  debounced button levels, for status LEDs/debug.

Behaviour:
- Reset: async assert, sync deassert is upstream's job. While i_reset_n=0:
  - o_sel = RST_SEL, o_sel_upd = 0, o_btn_db = 0.
  - Synchronisers and debounce counters cleared.
  - A reset mid-debounce discards the count. No press is reported from a button already held through reset until it is released and pressed again.
- Synchroniser: two flops per bit, no logic between them. Synchronised value sync[k] lags i_btn_raw[k] by 2 cycles.
- Debouncer: one counter per bit, width clog2(DEB_CYCLES+1).
  - While sync[k] == db[k]: counter = 0.
  - Otherwise the counter increments each cycle.
  - When the counter reaches DEB_CYCLES-1: db[k] takes sync[k] and the counter clears.
  - Any glitch back to db[k] before the limit restarts the count from 0.
  - Counter never wraps.
- Edge detect: press[k] = db[k] & ~db_q[k], where db_q is db delayed one cycle. Releases produce no event.
- Selection register, per cycle:
  - No press: o_sel holds.
  - One press k: o_sel = one-hot k.
  - Simultaneous presses: highest index wins (red > green > blue).
  - Press on the already-selected colour: o_sel unchanged, o_sel_upd = 0.
- o_sel_upd:
  - Asserted for exactly the cycle in which o_sel takes a new value (registered alongside o_sel).
  - Never asserted during or on the first cycle after reset.
- Latency from a clean raw rising edge to the o_sel update: 2 (sync) + DEB_CYCLES (debounce) + 1 (edge/select) cycles.
- A held button generates one press only. Auto-repeat is not provided.
- o_sel is always one-hot after the first press, or RST_SEL before it.

Test Plan (DEB_CYCLES=4 for simulation):
- Reset: i_reset_n=0 asserted mid-cycle → o_sel=3'b100, o_btn_db=0, o_sel_upd=0 immediately; all hold after release with no buttons pressed.
- Clean press: i_btn_raw=3'b001 held 20 cycles from reset state → o_btn_db[0]=1 after 6 cycles; o_sel=3'b001 with a single o_sel_upd pulse 1 cycle later; no further pulses while held or on release.
- Bounce rejection: i_btn_raw[1] toggles 1,0,1,0 every 2 cycles, then stays 0 → o_btn_db and o_sel unchanged, o_sel_upd never asserted. Then hold 1 for 10 cycles → o_sel=3'b010, one pulse.
- Simultaneous: clean press of 3'b011 from o_sel=3'b100 → o_sel=3'b010 (green over blue), one pulse. Then 3'b111 → o_sel=3'b100.
- Redundant press: o_sel=3'b100, press and release red → o_sel stays 3'b100, o_sel_upd stays 0.
- Reset mid-debounce: raw green high for 3 cycles, pulse i_reset_n low, keep green held → no selection change until green is released (≥4 cycles) and pressed again.
